sdfa_layer_sequencer: RTL

//  Sequences the SDFA conv datapath layer by layer, sitting below the top controller.
//  Per layer: accepts one config word, requests an input-buffer fill, then issues channel/row tiles.

---
 rtl/sdfa_ctrl_pkg.sv | 27 ++
 rtl/sdfa_tile_counter.sv | 56 +++++
 rtl/sdfa_layer_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdfa_ctrl_pkg.sv
// Shared definitions for the SDFA layer sequencer: state encoding, config word layout
// and default sizing.
package sdfa_ctrl_pkg;

  localparam int DEF_NUM_LAYERS_MAX = 8;
  localparam int DEF_ROW_W          = 5;
  localparam int DEF_CH_W           = 5;
  localparam int DEF_CFG_W          = 16;
  localparam int TYPE_W             = 3;

  localparam int CFG_TYPE_LSB = 0;
  localparam int CFG_NROW_LSB = 3;
  localparam int CFG_NCH_LSB  = 8;
  localparam int CFG_LAST_BIT = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_FILL  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/sdfa_tile_counter.sv
// Nested tile counter: row is the inner index, channel the outer one.
// A single inc moves to the next row, or wraps row to 0 and steps the channel.
module sdfa_tile_counter
  import sdfa_ctrl_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int CH_W  = DEF_CH_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic [ROW_W-1:0] n_row,
  input  logic [CH_W-1:0]  n_ch,
  output logic [ROW_W-1:0] row,
  output logic [CH_W-1:0]  ch,
  output logic             row_last,
  output logic             ch_last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  // Comparisons use >= so a counter can never run past its limit, even at 31.
  assign row_last = (row_q >= n_row);
  assign ch_last  = (ch_q >= n_ch);
  assign row      = row_q;
  assign ch       = ch_q;

  always_comb begin
    row_d = row_q;
    ch_d  = ch_q;
    if (clr) begin
      row_d = '0;
      ch_d  = '0;
    end else if (inc) begin
      if (!row_last) begin
        row_d = row_q + ROW_W'(1);
      end else begin
        row_d = '0;
        if (!ch_last) ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_q <= '0;
      ch_q  <= '0;
    end else begin
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

endmodule

// File: rtl/sdfa_layer_sequencer.sv
// Layer-by-layer sequencer for the SDFA conv datapath: config, buffer fill, tile issue
// and writeback per channel tile. All handshake outputs are registered from next state.
module sdfa_layer_sequencer
  import sdfa_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS_MAX = DEF_NUM_LAYERS_MAX,
  parameter int ROW_W          = DEF_ROW_W,
  parameter int CH_W           = DEF_CH_W,
  parameter int CFG_W          = DEF_CFG_W,
  localparam int LAYER_W       = $clog2(NUM_LAYERS_MAX)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               cfg_valid,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic               cfg_ready,
  output logic               fill_req,
  input  logic               in_filled,
  output logic               tile_start,
  output logic [ROW_W-1:0]   tile_row,
  output logic [CH_W-1:0]    tile_ch,
  input  logic               tile_done,
  output logic               wb_req,
  input  logic               wb_done,
  output logic [TYPE_W-1:0]  conv_inf,
  output logic [LAYER_W-1:0] layer,
  output logic               busy,
  output logic               seq_done,
  output logic               err,
  output state_t             dbg_state
);

  // Handshakes: a transfer happens on a posedge where the request level (cfg_ready,
  // fill_req, wb_req, or WAIT for tiles) and the matching response are both high.
  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [TYPE_W-1:0]  conv_inf_q, conv_inf_d;
  logic [ROW_W-1:0]   n_row_q, n_row_d;
  logic [CH_W-1:0]    n_ch_q, n_ch_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               fill_hold_q, fill_hold_d;
  logic               cfg_ready_q, fill_req_q, tile_start_q, wb_req_q, busy_q, seq_done_q;
  logic               cnt_clr, cnt_inc, row_last, ch_last;
  logic               unused_rsvd;

  assign unused_rsvd = ^cfg_data[CFG_W-1:CFG_LAST_BIT+1];

  sdfa_tile_counter #(.ROW_W(ROW_W), .CH_W(CH_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .n_row    (n_row_q),
    .n_ch     (n_ch_q),
    .row      (tile_row),
    .ch       (tile_ch),
    .row_last (row_last),
    .ch_last  (ch_last)
  );

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    conv_inf_d = conv_inf_q;
    n_row_d    = n_row_q;
    n_ch_d     = n_ch_q;
    last_d     = last_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CFG;
        err_d   = 1'b0;
        layer_d = '0;
      end
      S_CFG: if (cfg_valid && cfg_ready_q) begin
        conv_inf_d = cfg_data[CFG_TYPE_LSB +: TYPE_W];
        n_row_d    = cfg_data[CFG_NROW_LSB +: ROW_W];
        n_ch_d     = cfg_data[CFG_NCH_LSB +: CH_W];
        last_d     = cfg_data[CFG_LAST_BIT];
        state_d    = S_FILL;
      end
      S_FILL: if (in_filled) begin
        cnt_clr = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (tile_done) begin
        cnt_inc = !row_last;
        state_d = row_last ? S_WB : S_ISSUE;
      end
      S_WB: if (wb_done) begin
        cnt_inc = !ch_last;
        state_d = ch_last ? S_NEXT : S_ISSUE;
      end
      S_NEXT: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (layer_q == LAYER_W'(NUM_LAYERS_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = S_CFG;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Out-of-phase responses flag an error but are otherwise dropped. A still-high
    // in_filled that started during FILL is tolerated until it falls.
    if (state_q != S_IDLE) begin
      if (tile_done && !(state_q == S_WAIT || state_q == S_ISSUE)) err_d = 1'b1;
      if (wb_done && state_q != S_WB) err_d = 1'b1;
      if (in_filled && state_q != S_FILL && !fill_hold_q) err_d = 1'b1;
    end
    fill_hold_d = in_filled && (state_q == S_FILL || fill_hold_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      conv_inf_q   <= '0;
      n_row_q      <= '0;
      n_ch_q       <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      fill_hold_q  <= 1'b0;
      cfg_ready_q  <= 1'b0;
      fill_req_q   <= 1'b0;
      tile_start_q <= 1'b0;
      wb_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      conv_inf_q   <= conv_inf_d;
      n_row_q      <= n_row_d;
      n_ch_q       <= n_ch_d;
      last_q       <= last_d;
      err_q        <= err_d;
      fill_hold_q  <= fill_hold_d;
      cfg_ready_q  <= (state_d == S_CFG);
      fill_req_q   <= (state_d == S_FILL);
      tile_start_q <= (state_d == S_ISSUE);
      wb_req_q     <= (state_d == S_WB);
      busy_q       <= (state_d != S_IDLE);
      seq_done_q   <= (state_d == S_DONE);
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign fill_req   = fill_req_q;
  assign tile_start = tile_start_q;
  assign wb_req     = wb_req_q;
  assign busy       = busy_q;
  assign seq_done   = seq_done_q;
  assign err        = err_q;
  assign conv_inf   = conv_inf_q;
  assign layer      = layer_q;
  assign dbg_state  = state_q;

endmodule
